// File: rtl/tlc_intersection_model.sv
`default_nettype none
// ============================================================================
// tlc_intersection_model : intersection model for the 3-street light controller
//   Keeps per-lane car queues, feeds the sensors back and flags sequencing errors.
// Rev 1.0
// ============================================================================
module tlc_intersection_model #(
  parameter int QW   = 4,
  parameter int SW   = 16,
  parameter int YLEN = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    ew_str_light,
  input  logic [1:0]    ew_left_light,
  input  logic [1:0]    ns_light,
  input  logic          arr_ew_str,
  input  logic          arr_ew_left,
  input  logic          arr_ns,
  output logic          ew_str_sensor,
  output logic          ew_left_sensor,
  output logic          ns_sensor,
  output logic [QW-1:0] q_ew_str,
  output logic [QW-1:0] q_ew_left,
  output logic [QW-1:0] q_ns,
  output logic [SW-1:0] served_ew_str,
  output logic [SW-1:0] served_ew_left,
  output logic [SW-1:0] served_ns,
  output logic [2:0]    overflow,
  output logic [3:0]    err
);

  // Encoding follows the light_package colour enum (red, yellow, green).
  localparam logic [1:0] c_RED    = 2'd0;
  localparam logic [1:0] c_YELLOW = 2'd1;
  localparam logic [1:0] c_GREEN  = 2'd2;

  localparam int              YW     = $clog2(YLEN + 2) + 1;
  localparam logic [YW-1:0]   c_YLEN = YW'(YLEN);
  localparam logic [QW-1:0]   c_QMAX = '1;

  logic [1:0]    w_light  [3];
  logic [2:0]    w_arr;
  logic [QW-1:0] w_q      [3];
  logic [SW-1:0] w_served [3];

  logic [2:0] w_nonred;
  logic [2:0] w_was_yellow;
  logic [2:0] w_red2green;
  logic [2:0] w_ovf_set;
  logic [2:0] w_yerr;
  logic [2:0] w_bad_trans;

  logic       w_conflict;
  logic       w_no_gap;

  logic [2:0] r_overflow;
  logic [3:0] r_err;

  // Lane index: 0 = EW straight, 1 = EW left, 2 = NS.
  assign w_light[0] = ew_str_light;
  assign w_light[1] = ew_left_light;
  assign w_light[2] = ns_light;
  assign w_arr      = {arr_ns, arr_ew_left, arr_ew_str};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_lane
      logic [QW-1:0] r_q;
      logic [SW-1:0] r_served;
      logic [1:0]    r_prev;
      logic [YW-1:0] r_yrun;
      logic          w_dep;
      logic          w_legal;

      assign w_dep           = (w_light[i] == c_GREEN) && (r_q != '0);
      assign w_nonred[i]     = (w_light[i] != c_RED);
      assign w_was_yellow[i] = (r_prev == c_YELLOW);
      assign w_red2green[i]  = (r_prev == c_RED) && (w_light[i] == c_GREEN);
      assign w_ovf_set[i]    = w_arr[i] && !w_dep && (r_q == c_QMAX);

      // A yellow run is wrong if it ends short/long, or is about to exceed YLEN.
      assign w_yerr[i] = (w_was_yellow[i] && (w_light[i] != c_YELLOW) && (r_yrun != c_YLEN))
                       || ((w_light[i] == c_YELLOW) && (r_yrun == c_YLEN));

      // Anything not in the legal list, including out-of-enum codes, is illegal.
      always_comb begin
        w_legal = 1'b0;
        case ({r_prev, w_light[i]})
          {c_GREEN,  c_GREEN},
          {c_GREEN,  c_YELLOW},
          {c_YELLOW, c_YELLOW},
          {c_YELLOW, c_RED},
          {c_RED,    c_RED},
          {c_RED,    c_GREEN}:  w_legal = 1'b1;
          default:              w_legal = 1'b0;
        endcase
      end
      assign w_bad_trans[i] = !w_legal;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_q      <= '0;
          r_served <= '0;
          r_prev   <= c_RED;
          r_yrun   <= '0;
        end else begin
          r_prev <= w_light[i];

          if (w_light[i] == c_YELLOW) begin
            if (r_yrun != '1) begin
              r_yrun <= r_yrun + 1'b1;
            end
          end else begin
            r_yrun <= '0;
          end

          if (w_arr[i] && !w_dep && (r_q != c_QMAX)) begin
            r_q <= r_q + 1'b1;
          end else if (!w_arr[i] && w_dep) begin
            r_q <= r_q - 1'b1;
          end

          if (w_dep) begin
            r_served <= r_served + 1'b1;
          end
        end
      end

      assign w_q[i]      = r_q;
      assign w_served[i] = r_served;
    end
  endgenerate

  assign w_conflict = (w_nonred[0] & w_nonred[1])
                    | (w_nonred[0] & w_nonred[2])
                    | (w_nonred[1] & w_nonred[2]);
  assign w_no_gap   = (|w_red2green) && (|w_was_yellow);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= '0;
      r_err      <= '0;
    end else begin
      r_overflow <= r_overflow | w_ovf_set;
      r_err      <= r_err | {w_no_gap, |w_bad_trans, |w_yerr, w_conflict};
    end
  end

  assign q_ew_str       = w_q[0];
  assign q_ew_left      = w_q[1];
  assign q_ns           = w_q[2];
  assign ew_str_sensor  = (w_q[0] != '0);
  assign ew_left_sensor = (w_q[1] != '0);
  assign ns_sensor      = (w_q[2] != '0);
  assign served_ew_str  = w_served[0];
  assign served_ew_left = w_served[1];
  assign served_ns      = w_served[2];
  assign overflow       = r_overflow;
  assign err            = r_err;

endmodule
`default_nettype wire
